// File: rtl/alu_sweep_sequencer.sv
// Sweeps a 4-bit ALU through all eight sel codes for one latched operand pair,
// buffers the results and streams them out over valid/ready.
// Optional self-check of the captured results: define ALU_SELFCHECK_EN.
module alu_sweep_sequencer #(
    parameter int unsigned DW     = 4,
    parameter int unsigned RW     = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          busy,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [RW-1:0] alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_sel,
    output logic [RW-1:0] out_data,
    output logic          out_last,
    output logic          done
`ifdef ALU_SELFCHECK_EN
    ,
    output logic          mismatch,
    output logic [3:0]    err_cnt
`endif
);

    localparam int unsigned CW    = $clog2(SETTLE + 1);
    localparam int unsigned NBEAT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;
    logic [2:0]    rd_ptr_q, rd_ptr_d;
    logic [RW-1:0] cap_q [NBEAT];
    logic [RW-1:0] cap_d [NBEAT];
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic [2:0]    out_sel_q, out_sel_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;

`ifdef ALU_SELFCHECK_EN
    logic          mismatch_q, mismatch_d;
    logic [3:0]    err_cnt_q, err_cnt_d;
    logic [RW-1:0] exp_c;

    // Golden ALU behaviour, operands zero-extended to the result width
    function automatic logic [RW-1:0] alu_expected(input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b,
                                                   input logic [2:0]    sel);
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        logic [DW-1:0] na;
        ax = RW'(a);
        bx = RW'(b);
        na = ~a;
        case (sel)
            3'd0:    alu_expected = ax + bx;
            3'd1:    alu_expected = ax - bx;
            3'd2:    alu_expected = ax << 1;
            3'd3:    alu_expected = ax & bx;
            3'd4:    alu_expected = ax | bx;
            3'd5:    alu_expected = RW'(na);
            3'd6:    alu_expected = ax ^ bx;
            default: alu_expected = bx >> 1;
        endcase
    endfunction

    assign exp_c = alu_expected(alu_a_q, alu_b_q, alu_sel_q);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rd_ptr_d    = rd_ptr_q;
        cap_d       = cap_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef ALU_SELFCHECK_EN
        mismatch_d  = mismatch_q;
        err_cnt_d   = err_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    alu_a_d   = op_a;
                    alu_b_d   = op_b;
                    alu_sel_d = 3'd0;
                    cnt_d     = '0;
                    state_d   = SWEEP;
`ifdef ALU_SELFCHECK_EN
                    mismatch_d = 1'b0;
                    err_cnt_d  = 4'd0;
`endif
                end
            end

            SWEEP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(SETTLE)) begin
                    cap_d[alu_sel_q] = alu_result;
`ifdef ALU_SELFCHECK_EN
                    if (alu_result != exp_c) begin
                        mismatch_d = 1'b1;
                        if (err_cnt_q != 4'hF) begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                    end
`endif
                    if (alu_sel_q == 3'd7) begin
                        state_d  = DRAIN;
                        rd_ptr_d = 3'd0;
                    end else begin
                        alu_sel_d = alu_sel_q + 3'd1;
                        cnt_d     = '0;
                    end
                end
            end

            DRAIN: begin
                // First DRAIN cycle loads beat 0 into the output register
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_sel_d   = rd_ptr_q;
                    out_data_d  = cap_q[rd_ptr_q];
                    out_last_d  = (rd_ptr_q == 3'd7);
                end else if (out_ready) begin
                    if (rd_ptr_q == 3'd7) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 3'd1;
                        out_sel_d  = rd_ptr_d;
                        out_data_d = cap_q[rd_ptr_d];
                        out_last_d = (rd_ptr_d == 3'd7);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < int'(NBEAT); i++) begin
                cap_q[i] <= '0;
            end
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef ALU_SELFCHECK_EN
            mismatch_q  <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rd_ptr_q    <= rd_ptr_d;
            cap_q       <= cap_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
`ifdef ALU_SELFCHECK_EN
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
`ifdef ALU_SELFCHECK_EN
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/alu_sweep_sequencer.md
# alu_sweep_sequencer

Synthesizable stimulus-and-capture engine for the 4-bit ALU. It latches one operand pair, drives the ALU through all eight `sel` codes (000..111) and captures each 8-bit `result` into an internal 8-entry buffer. It then streams the captured results out over a valid/ready interface. It sits between a host or controller and the combinational ALU instance, replacing bench-driven sel sweeps in on-chip bring-up.

## Interface
Parameters:
- `DW`, 4, operand width (ALU `a`/`b`)
- `RW`, 8, result width (ALU `result`)
- `SETTLE`, 1, cycles (≥1) between driving `alu_sel` and sampling `alu_result`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  sweep request, sampled only in IDLE
- `op_a`  in  DW  operand A, latched on accepted `start`
- `op_b`  in  DW  operand B, latched on accepted `start`
- `busy`  out  1  high in any state other than IDLE
- `alu_a`  out  DW  registered drive to ALU `a`
- `alu_b`  out  DW  registered drive to ALU `b`
- `alu_sel`  out  3  registered drive to ALU `sel`
- `alu_result`  in  RW  ALU `result`
- `out_valid`  out  1  result beat available
- `out_ready`  in  1  downstream accepts the beat
- `out_sel`  out  3  sel code of the current beat
- `out_data`  out  RW  captured result of the current beat
- `out_last`  out  1  high on the beat where `out_sel`=111
- `done`  out  1  one-cycle pulse after the last beat transfers
- `mismatch`  out  1  (ALU_SELFCHECK_EN only) sticky; any captured result differed from the expected value
- `err_cnt`  out  4  (ALU_SELFCHECK_EN only) saturating count of mismatching captures

## Operation
- FSM states: IDLE, SWEEP, DRAIN.
- **IDLE**
  - `start`=1 latches `op_a`/`op_b` into `alu_a`/`alu_b`, sets `alu_sel`=000 and the settle counter to 0.
  - Moves to SWEEP.
- **SWEEP**
  - The settle counter increments each cycle.
  - When it reaches `SETTLE`, `alu_result` is written to `buf[alu_sel]` at that edge.
  - If `alu_sel`=111, the FSM moves to DRAIN with read pointer 0.
  - Otherwise `alu_sel` increments and the counter clears.
  - `start` is ignored.
- **DRAIN**
  - `out_valid`=1.
  - `out_sel` equals the read pointer and `out_data`=`buf[pointer]`.
  - A transfer occurs when `out_valid`&&`out_ready`; the pointer then increments.
  - Transfer at pointer 7 → IDLE, with `done`=1 for one cycle.
  - `out_data`/`out_sel` stay stable while `out_valid`=1 and `out_ready`=0.
- **Hold values:** `alu_a`, `alu_b` and `alu_sel` hold their last values in DRAIN and IDLE. There is no wrap back to 000 until the next `start`.
- **Capture semantics:** `buf` stores `alu_result` verbatim (RW bits); no width conversion is applied.
- **`start` during DRAIN:** ignored, not queued.
- **Reset mid-operation:**
  - Immediate return to IDLE; the buffer contents are don't-care.
  - Any partially drained stream is abandoned.
  - No `done` is generated.

## Timing
- **Reset values:**
  - `busy`, `out_valid`, `out_last`, `done`, `mismatch` = 0
  - `alu_a`, `alu_b`, `alu_sel`, `out_sel`, `err_cnt` = 0
  - `out_data` = 0
- **`busy`:** rises the cycle after `start` is accepted.
- **Sweep latency:** SWEEP lasts 8×SETTLE cycles. With `SETTLE`=1, the first `out_valid` occurs 9 cycles after the `start` edge.
- **Drain:** minimum 8 cycles with `out_ready` held high.
- **`done`:** asserts the cycle after the last transfer, together with `busy`=0.
- **Back-to-back sweeps:** `start` high on the `done` cycle is accepted.
- All outputs are registered; there is no combinational path from `alu_result` or `out_ready` to any output.

## Configuration
- Macro: `ALU_SELFCHECK_EN`.
- **Defined:** an internal reference model computes the expected value at each capture. All arithmetic is 8-bit, with operands zero-extended:
  - 000: a+b
  - 001: a−b, modulo 256
  - 010: a<<1
  - 011: a&b
  - 100: a|b
  - 101: {4'b0, ~a}
  - 110: a^b
  - 111: b>>1

  On each capture that differs from the expected value, `mismatch` is set and `err_cnt` increments, saturating at 15. Both are cleared only by reset or by an accepted `start`.
- **Undefined:** the model, `mismatch` and `err_cnt` are absent from the port list. No other behaviour changes.

## Test plan
- **Full sweep:** reset, then `start` with a=3, b=2, `out_ready`=1, ALU attached. Required: beats (sel:data) 0:5, 1:1, 2:6, 3:2, 4:3, 5:12, 6:1, 7:1, with `out_last` only on beat 7 and `done` one cycle after it.
- **Backpressure:** as above, with `out_ready` toggled 1,0,0,1,... Required: `out_data`/`out_sel` held stable while stalled, no beat dropped or duplicated, and exactly 8 transfers.
- **Settle and ignored start:** `SETTLE`=3 with `start` pulsed again during SWEEP. Required: each `alu_sel` held 3 cycles, the second `start` ignored, and the first `out_valid` at cycle 25.
- **Reset mid-operation:** assert `rst_n`=0 during DRAIN after 3 beats. Required: all outputs at their reset values immediately, no `done`. A new `start` with a=15, b=15 yields sel1 data 0 and sel5 data 0.
- **Self-check (ALU_SELFCHECK_EN):** force `alu_result` bit 0 inverted for sel=2 only. Required: `mismatch`=1 and `err_cnt`=1 after the sweep; both return to 0 on the next `start`.
- **Back-to-back:** `start` held high continuously. Required: a new sweep begins on the `done` cycle, and `busy` drops for exactly that one cycle.
